// File: rtl/delay91_ctrl.sv
// Request/acknowledge sequencer around an external 91-cycle counter: loads it,
// checks that its done level arrives exactly on time, and counts completions.
//
// state | meaning
// IDLE  | ready for a request
// LOAD  | one-cycle load pulse to the downstream counter
// WAIT  | counting elapsed cycles k, waiting for dn at k=92
// ERR   | early/late dn or timeout; sticky err until clr_err
module delay91_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   output logic       ld,
   input  logic       dn,
   output logic       done,
   output logic       busy,
   output logic       err,
   input  logic       clr_err,
   output logic [7:0] cnt
);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, ERR} state_t;

   localparam logic [6:0] K_DONE    = 7'd92;
   localparam logic [6:0] K_TIMEOUT = 7'd100;

   state_t     state;
   logic [6:0] k;

   // Outputs are registered alongside the state transition, so each output
   // reflects the state being entered rather than decoding inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         req_ready <= 1'b1;
         ld        <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         cnt       <= '0;
      end else begin
         ld   <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state     <= LOAD;
                  ld        <= 1'b1;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
               end
            end
            LOAD: begin
               state <= WAIT;
               k     <= 7'd1;
            end
            WAIT: begin
               if (dn && (k == K_DONE)) begin
                  state     <= IDLE;
                  done      <= 1'b1;
                  cnt       <= cnt + 8'd1;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  k         <= '0;
               end else if (dn || (k == K_TIMEOUT)) begin
                  // dn before or after k=92 is a protocol error, as is no dn by k=100
                  state <= ERR;
                  busy  <= 1'b0;
                  k     <= '0;
               end else begin
                  k <= k + 7'd1;
               end
            end
            ERR: begin
               if (clr_err) begin
                  state     <= IDLE;
                  err       <= 1'b0;
                  req_ready <= 1'b1;
               end else begin
                  err <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               req_ready <= 1'b1;
               k         <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_delay91_ctrl.sv
// Directed bench for delay91_ctrl: nominal delay, early dn, timeout,
// back-to-back requests, reset mid-WAIT and completion-count wrap.
module tb_delay91_ctrl;

   logic       clk = 1'b0;
   logic       rst, req_valid, dn, clr_err;
   logic       req_ready, ld, done, busy, err;
   logic [7:0] cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int done_seen = 0;
   int s, seen0;
   logic [7:0] exp_cnt;

   delay91_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .ld        (ld),
      .dn        (dn),
      .done      (done),
      .busy      (busy),
      .err       (err),
      .clr_err   (clr_err),
      .cnt       (cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_seen++;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_ld"},    32'(ld),        32'd0);
      chk({tag, "_done"},  32'(done),      32'd0);
      chk({tag, "_busy"},  32'(busy),      32'd0);
      chk({tag, "_err"},   32'(err),       32'd0);
      chk({tag, "_cnt"},   32'(cnt),       32'd0);
   endtask

   // One complete delay from IDLE; returns in the cycle after the done pulse.
   task automatic run_delay(input string tag);
      req_valid = 1'b1;
      tick();
      chk({tag, "_ld"}, 32'(ld), 32'd1);
      req_valid = 1'b0;
      tick(92);
      dn = 1'b1;
      tick();
      dn = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_cnt"},  32'(cnt),  32'(exp_cnt));
      tick();
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; dn = 1'b0; clr_err = 1'b0;
      exp_cnt = 8'd0;
      tick(2);
      chk_reset_vals("reset");
      rst = 1'b0;

      // Nominal: request in cycle 0, ld at 1, dn at 93, done at 94
      req_valid = 1'b1;
      chk("nom_ready0", 32'(req_ready), 32'd1);
      tick();
      chk("nom_ld1",     32'(ld),        32'd1);
      chk("nom_busy1",   32'(busy),      32'd1);
      chk("nom_ready1",  32'(req_ready), 32'd0);
      req_valid = 1'b0;
      tick();
      chk("nom_ld2",     32'(ld),        32'd0);
      chk("nom_busy2",   32'(busy),      32'd1);
      tick(90);
      chk("nom_busy92",  32'(busy),      32'd1);
      chk("nom_done92",  32'(done),      32'd0);
      tick();
      dn = 1'b1;
      tick();
      dn = 1'b0;
      chk("nom_done94",  32'(done),      32'd1);
      chk("nom_cnt94",   32'(cnt),       32'd1);
      chk("nom_busy94",  32'(busy),      32'd0);
      chk("nom_ready94", 32'(req_ready), 32'd1);
      tick();
      chk("nom_done95",  32'(done),      32'd0);
      chk("nom_cnt95",   32'(cnt),       32'd1);

      // dn and clr_err in IDLE are ignored
      dn = 1'b1; clr_err = 1'b1;
      tick();
      dn = 1'b0; clr_err = 1'b0;
      chk("idle_dn_done", 32'(done),      32'd0);
      chk("idle_dn_busy", 32'(busy),      32'd0);
      chk("idle_dn_rdy",  32'(req_ready), 32'd1);
      chk("idle_dn_err",  32'(err),       32'd0);

      // Early dn at k=50
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick(50);
      dn = 1'b1;
      tick();
      dn = 1'b0;
      chk("early_busy51",  32'(busy),      32'd0);
      chk("early_ready51", 32'(req_ready), 32'd0);
      tick();
      chk("early_err52",   32'(err),       32'd1);
      chk("early_cnt52",   32'(cnt),       32'd1);
      chk("early_done52",  32'(done),      32'd0);
      req_valid = 1'b1;
      tick(3);
      chk("early_ld_ign",  32'(ld),        32'd0);
      chk("early_err_hold",32'(err),       32'd1);
      chk("early_rdy_hold",32'(req_ready), 32'd0);
      req_valid = 1'b0;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("early_clr_err", 32'(err),       32'd0);
      chk("early_clr_rdy", 32'(req_ready), 32'd1);
      chk("early_clr_cnt", 32'(cnt),       32'd1);

      // Timeout: no dn, k reaches 100 at t+100, err visible at t+102
      seen0 = done_seen;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick(100);
      chk("to_busy100", 32'(busy), 32'd1);
      chk("to_err100",  32'(err),  32'd0);
      tick();
      chk("to_busy101", 32'(busy), 32'd0);
      chk("to_err101",  32'(err),  32'd0);
      tick();
      chk("to_err102",  32'(err),  32'd1);
      chk("to_nodone",  32'(done_seen - seen0), 32'd0);
      chk("to_cnt",     32'(cnt),  32'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("to_clr_err", 32'(err), 32'd0);

      // Back-to-back: req_valid held, ld at 1, 95, 189 relative to cycle 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("b2b_rst_cnt", 32'(cnt), 32'd0);
      seen0 = done_seen;
      s = cyc;
      req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("b2b_ld",     32'(ld),      32'd1);
         chk("b2b_ld_cyc", 32'(cyc - s), 32'(1 + 94 * i));
         tick(92);
         dn = 1'b1;
         tick();
         dn = 1'b0;
         chk("b2b_done",   32'(done),      32'd1);
         chk("b2b_ready",  32'(req_ready), 32'd1);
      end
      req_valid = 1'b0;
      tick();
      chk("b2b_cnt",   32'(cnt), 32'd3);
      chk("b2b_ndone", 32'(done_seen - seen0), 32'd3);
      chk("b2b_noreq", 32'(busy), 32'd0);

      // Reset at k=40 mid-WAIT, with req_valid also high: reset wins
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick(40);
      chk("rmw_busy40", 32'(busy), 32'd1);
      rst = 1'b1; req_valid = 1'b1;
      tick();
      chk_reset_vals("rmw");
      tick();
      chk("rmw_prio_ld", 32'(ld), 32'd0);
      rst = 1'b0; req_valid = 1'b0;
      seen0 = done_seen;
      tick(51);
      dn = 1'b1;
      tick();
      dn = 1'b0;
      tick();
      chk("rmw_nodone", 32'(done_seen - seen0), 32'd0);
      chk("rmw_ld",     32'(ld),   32'd0);
      chk("rmw_busy",   32'(busy), 32'd0);
      chk("rmw_cnt",    32'(cnt),  32'd0);

      // Wrap: 256 completions return cnt to 0
      exp_cnt = 8'd0;
      for (int i = 0; i < 256; i++) run_delay("wrap");
      chk("wrap_cnt0", 32'(cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
